inst_rom_arbiter: RTL and testbench
===================================

# inst_rom_arbiter

Shares the single combinational read port of the instruction ROM between two requesters: port 0 (IF stage fetch) and port 1 (debug/loader read-back). Each cycle it grants at most one request, drives the ROM `ce`/`addr`, and returns the 64-bit word through a registered response one cycle later. Arbitration is round-robin. Port 0 additionally has a flush input that cancels its in-flight response on a branch or exception.

## Interface
- `ADDR_W`, 32: byte address width (`InstAddrBus`).
- `DATA_W`, 64: instruction width (`InstBus`).
- `MEM_NUM`, 131072: ROM depth in 64-bit words (`InstMemNum`).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_i`, `req1_i`  in  1  read request, ports 0/1.
- `addr0_i`, `addr1_i`  in  ADDR_W  byte address, ports 0/1.
- `gnt0_o`, `gnt1_o`  out  1  combinational grant; the request is accepted in this cycle.
- `rvalid0_o`, `rvalid1_o`  out  1  registered response valid, ports 0/1.
- `rdata_o`  out  DATA_W  registered response word; shared by both ports.
- `rerr_o`  out  1  registered error flag; valid together with either `rvalid`.
- `flush0_i`  in  1  cancels port 0's pending response.
- `rom_ce_o`  out  1  ROM chip enable, `ChipEnable` when a grant is issued.
- `rom_addr_o`  out  ADDR_W  ROM address, the granted port's address.
- `rom_inst_i`  in  DATA_W  ROM read data (combinational).

## Operation
- **Request rule:** a requester holds `req`/`addr` stable until it sees `gnt` high. After a grant it may issue a new request in the very next cycle.
- **Arbitration:**
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port pointed to by `last_q` loses. `last_q` records the most recently granted port.
  - `last_q` updates on every grant.
  - Reset value of `last_q` = 1, so port 0 wins the first tie.
- **ROM drive:**
  - No grant: `rom_ce_o` = `ChipDisable` and `rom_addr_o` = 0.
  - Grant: `rom_ce_o` = `ChipEnable` and `rom_addr_o` = the granted port's address.
- **Error check:** `err` = addr[2:0] ≠ 0 or addr[ADDR_W-1:3] ≥ MEM_NUM.
- **Response capture:** at the clock edge after a grant:
  - `rdata_o` ← `rom_inst_i`, or `ZeroDoubleWord` if `err` is set.
  - `rerr_o` ← `err`.
  - `rvalid` is set for the granted port only.
  - With no grant, both `rvalid` outputs clear. `rdata_o` and `rerr_o` hold their previous values.
- **Flush:**
  - `flush0_i` high in the cycle port 0 is granted: that response is suppressed (`rvalid0_o` stays 0 next cycle). `last_q` still updates.
  - `flush0_i` high while `rvalid0_o` is already high: the visible response is unaffected.
  - `flush0_i` has no effect on port 1.
- **State:** `last_q`, `rvalid0_q`, `rvalid1_q`, `rdata_q`, `rerr_q`. No other state.

## Timing
- **Grant:** `gnt` is combinational from `req*` and `last_q`. It is never high for a port whose `req` is low.
- **Latency:** grant cycle N gives `rvalid` and `rdata` in cycle N+1.
- **Throughput:** one response per cycle in total. Under continuous contention each port gets 1 grant per 2 cycles.
- **Reset values:** `rvalid0_o` = `rvalid1_o` = 0, `rdata_o` = 0, `rerr_o` = 0, `last_q` = 1.
- **Combinational outputs during reset:** `gnt*` = 0, `rom_ce_o` = `ChipDisable`, `rom_addr_o` = 0.
- **Reset mid-transaction:** asserting reset while a grant is pending discards it. There is no response after reset is released. Requesters re-request.
- **Simultaneous events:** a grant to port 1 and a flush in the same cycle → the port 1 response is delivered normally.

## Structure
- Use `ChipEnable`, `ChipDisable`, `ZeroDoubleWord`, `InstAddrBus`, `InstBus`, `InstMemNum` from the shared defines file.
- Add `PortIF` = 1'b0 and `PortDbg` = 1'b1 there.
- Single module, no sub-modules. The ROM is instantiated beside it, one level up.

## Test plan
- **Single port 0:** `req0_i`=1, `addr0_i`=0x8 for 1 cycle → `gnt0_o`=1, `rom_addr_o`=0x8; next cycle `rvalid0_o`=1, `rdata_o`=inst_mem[1], `rerr_o`=0.
- **Contention:** both ports request continuously with addr0=0x0 and addr1=0x10 → grants alternate 0,1,0,1 starting with port 0. `rvalid` toggles correspondingly, with `rdata_o` = words 0 and 2.
- **Misaligned address:** `req1_i`=1, `addr1_i`=0x4 → next cycle `rvalid1_o`=1, `rerr_o`=1, `rdata_o`=0. Repeat with addr ≥ MEM_NUM·8 → same response.
- **Flush:**
  - Port 0 granted at 0x0 with `flush0_i`=1 → next cycle `rvalid0_o`=0.
  - Flush asserted during `rvalid0_o`=1 → that response is still visible.
- **Reset mid-transaction:** pull `rst` low the cycle after a grant → all outputs return to reset values immediately. No `rvalid` after release. The first tie after release goes to port 0.
- **Idle:** no requests for 10 cycles → `rom_ce_o`=`ChipDisable`, both `rvalid`=0, `rdata_o` holds its last value.

Source files
------------

// File: rtl/inst_rom_arbiter_pkg.sv
// Shared defines for the instruction-fetch path: bus widths, ROM depth,
// chip-enable levels and the port identifiers used by the ROM arbiter.
package inst_rom_arbiter_pkg;

   localparam int   InstAddrBus = 32;
   localparam int   InstBus     = 64;
   localparam int   InstMemNum  = 131072;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;

   localparam logic [InstBus-1:0] ZeroDoubleWord = 64'h0;

   // Port identifiers, also the encoding of the "last granted" register.
   localparam logic PortIF  = 1'b0;
   localparam logic PortDbg = 1'b1;

endpackage

// File: rtl/inst_rom_arbiter.sv
// Round-robin share of the instruction ROM read port between the IF stage
// (port 0) and the debug/loader read-back (port 1), with a registered response.
module inst_rom_arbiter
   import inst_rom_arbiter_pkg::*;
#(
   parameter int ADDR_W  = InstAddrBus,
   parameter int DATA_W  = InstBus,
   parameter int MEM_NUM = InstMemNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic              req1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic              flush0_i,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              rvalid0_o,
   output logic              rvalid1_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rerr_o,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_inst_i
);

   logic              r_last_q;
   logic              r_rvalid0_q;
   logic              r_rvalid1_q;
   logic [DATA_W-1:0] r_rdata_q;
   logic              r_rerr_q;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_grant;
   logic [ADDR_W-1:0] w_addr;
   logic              w_err;

   // Grants are gated by reset so the ROM is idle while reset is held.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst) begin
         if (req0_i && (!req1_i || (r_last_q == PortDbg))) begin
            w_gnt0 = 1'b1;
         end else if (req1_i) begin
            w_gnt1 = 1'b1;
         end
      end
   end

   assign w_grant = w_gnt0 | w_gnt1;
   assign w_addr  = w_gnt1 ? addr1_i : (w_gnt0 ? addr0_i : '0);
   assign w_err   = (w_addr[2:0] != 3'b000) ||
                    ({3'b000, w_addr[ADDR_W-1:3]} >= ADDR_W'(MEM_NUM));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_q    <= PortDbg;
         r_rvalid0_q <= 1'b0;
         r_rvalid1_q <= 1'b0;
         r_rdata_q   <= '0;
         r_rerr_q    <= 1'b0;
      end else begin
         // A flushed port-0 grant still consumes its turn; only the valid is dropped.
         r_rvalid0_q <= w_gnt0 & ~flush0_i;
         r_rvalid1_q <= w_gnt1;
         if (w_grant) begin
            r_last_q  <= w_gnt1 ? PortDbg : PortIF;
            r_rdata_q <= w_err ? DATA_W'(ZeroDoubleWord) : rom_inst_i;
            r_rerr_q  <= w_err;
         end
      end
   end

   assign gnt0_o     = w_gnt0;
   assign gnt1_o     = w_gnt1;
   assign rom_ce_o   = w_grant ? ChipEnable : ChipDisable;
   assign rom_addr_o = w_addr;
   assign rvalid0_o  = r_rvalid0_q;
   assign rvalid1_o  = r_rvalid1_q;
   assign rdata_o    = r_rdata_q;
   assign rerr_o     = r_rerr_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter with a behavioural ROM whose word i
// is a fixed function of i.
module tb_inst_rom_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MEM_NUM = 131072;

  logic              clk;
  logic              rst;
  logic              req0_i, req1_i, flush0_i;
  logic [ADDR_W-1:0] addr0_i, addr1_i;
  logic              gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rerr_o, rom_ce_o;
  logic [DATA_W-1:0] rdata_o, rom_inst_i;
  logic [ADDR_W-1:0] rom_addr_o;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [63:0] exp_word(input logic [28:0] idx);
    return {32'hC0DE_0000 ^ {3'b000, idx}, ~{3'b000, idx}};
  endfunction

  assign rom_inst_i = exp_word(rom_addr_o[31:3]);

  inst_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_NUM(MEM_NUM)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .addr0_i(addr0_i),
    .req1_i(req1_i), .addr1_i(addr1_i),
    .flush0_i(flush0_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata_o(rdata_o), .rerr_o(rerr_o),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
    .rom_inst_i(rom_inst_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0_i = 1'b1; req1_i = 1'b1; flush0_i = 1'b0;
    addr0_i = 32'h8; addr1_i = 32'h10;
    tick(); tick();
    n_cmp++; if (gnt0_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0: got %b want 0", gnt0_o); end
    n_cmp++; if (gnt1_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1: got %b want 0", gnt1_o); end
    n_cmp++; if (rom_ce_o !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b want 0", rom_ce_o); end
    n_cmp++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", rom_addr_o); end
    n_cmp++; if ({rvalid0_o, rvalid1_o} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {rvalid0_o, rvalid1_o}); end
    n_cmp++; if (rdata_o !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    n_cmp++; if (rerr_o !== 1'b0) begin n_fail++; $display("FAIL rst_rerr: got %b want 0", rerr_o); end
    req0_i = 1'b0; req1_i = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  // Both ports request continuously; port 0 must win first after reset.
  task automatic test_contention();
    logic [63:0] w;
    req0_i = 1'b1; addr0_i = 32'h0;
    req1_i = 1'b1; addr1_i = 32'h10;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if ({gnt0_o, gnt1_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b want %b", k, {gnt0_o, gnt1_o}, (k % 2 == 0) ? 2'b10 : 2'b01); end
      n_cmp++; if (rom_addr_o !== ((k % 2 == 0) ? 32'h0 : 32'h10)) begin n_fail++; $display("FAIL cont_addr[%0d]: got %h", k, rom_addr_o); end
      tick();
      w = (k % 2 == 0) ? exp_word(29'd0) : exp_word(29'd2);
      n_cmp++; if ({rvalid0_o, rvalid1_o} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL cont_rvalid[%0d]: got %b", k, {rvalid0_o, rvalid1_o}); end
      n_cmp++; if (rdata_o !== w) begin n_fail++; $display("FAIL cont_rdata[%0d]: got %h want %h", k, rdata_o, w); end
    end
    req0_i = 1'b0; req1_i = 1'b0;
    tick();
  endtask

  task automatic test_single_port0();
    req0_i = 1'b1; addr0_i = 32'h8;
    #1;
    n_cmp++; if ({gnt0_o, gnt1_o} !== 2'b10) begin n_fail++; $display("FAIL single_gnt: got %b want 10", {gnt0_o, gnt1_o}); end
    n_cmp++; if (rom_ce_o !== 1'b1) begin n_fail++; $display("FAIL single_ce: got %b want 1", rom_ce_o); end
    n_cmp++; if (rom_addr_o !== 32'h8) begin n_fail++; $display("FAIL single_addr: got %h want 8", rom_addr_o); end
    tick();
    req0_i = 1'b0;
    n_cmp++; if ({rvalid0_o, rvalid1_o} !== 2'b10) begin n_fail++; $display("FAIL single_rvalid: got %b want 10", {rvalid0_o, rvalid1_o}); end
    n_cmp++; if (rdata_o !== exp_word(29'd1)) begin n_fail++; $display("FAIL single_rdata: got %h want %h", rdata_o, exp_word(29'd1)); end
    n_cmp++; if (rerr_o !== 1'b0) begin n_fail++; $display("FAIL single_rerr: got %b want 0", rerr_o); end
    tick();
  endtask

  task automatic test_addr_errors();
    logic [31:0] addrs [3];
    logic        errs  [3];
    logic [63:0] datas [3];
    addrs[0] = 32'h4;                  errs[0] = 1'b1; datas[0] = 64'h0;
    addrs[1] = MEM_NUM * 8;            errs[1] = 1'b1; datas[1] = 64'h0;
    addrs[2] = (MEM_NUM - 1) * 8;      errs[2] = 1'b0; datas[2] = exp_word(29'(MEM_NUM - 1));
    for (int k = 0; k < 3; k++) begin
      req1_i = 1'b1; addr1_i = addrs[k];
      #1;
      n_cmp++; if (gnt1_o !== 1'b1) begin n_fail++; $display("FAIL err_gnt[%0d]: got %b want 1", k, gnt1_o); end
      tick();
      req1_i = 1'b0;
      n_cmp++; if ({rvalid0_o, rvalid1_o} !== 2'b01) begin n_fail++; $display("FAIL err_rvalid[%0d]: got %b want 01", k, {rvalid0_o, rvalid1_o}); end
      n_cmp++; if (rerr_o !== errs[k]) begin n_fail++; $display("FAIL err_rerr[%0d]: got %b want %b", k, rerr_o, errs[k]); end
      n_cmp++; if (rdata_o !== datas[k]) begin n_fail++; $display("FAIL err_rdata[%0d]: got %h want %h", k, rdata_o, datas[k]); end
      tick();
    end
  endtask

  // Entered with port 1 as last grant.
  task automatic test_flush();
    req0_i = 1'b1; addr0_i = 32'h0; flush0_i = 1'b1;
    #1;
    n_cmp++; if (gnt0_o !== 1'b1) begin n_fail++; $display("FAIL flush_gnt: got %b want 1", gnt0_o); end
    tick();
    req0_i = 1'b0; flush0_i = 1'b0;
    n_cmp++; if (rvalid0_o !== 1'b0) begin n_fail++; $display("FAIL flush_suppress: got %b want 0", rvalid0_o); end
    // The flushed grant still counts as port 0's turn, so port 1 wins the tie.
    req0_i = 1'b1; addr0_i = 32'h18; req1_i = 1'b1; addr1_i = 32'h20;
    #1;
    n_cmp++; if ({gnt0_o, gnt1_o} !== 2'b01) begin n_fail++; $display("FAIL flush_last: got %b want 01", {gnt0_o, gnt1_o}); end
    tick();
    req1_i = 1'b0;
    n_cmp++; if (rvalid1_o !== 1'b1 || rdata_o !== exp_word(29'd4)) begin n_fail++; $display("FAIL flush_p1resp: got %b/%h want 1/%h", rvalid1_o, rdata_o, exp_word(29'd4)); end
    n_cmp++; if (gnt0_o !== 1'b1) begin n_fail++; $display("FAIL flush_held_gnt: got %b want 1", gnt0_o); end
    tick();
    req0_i = 1'b0; flush0_i = 1'b1;
    #1;
    n_cmp++; if (rvalid0_o !== 1'b1 || rdata_o !== exp_word(29'd3)) begin n_fail++; $display("FAIL flush_visible: got %b/%h want 1/%h", rvalid0_o, rdata_o, exp_word(29'd3)); end
    // Flush concurrent with a port 1 grant has no effect.
    req1_i = 1'b1; addr1_i = 32'h28;
    #1;
    n_cmp++; if (gnt1_o !== 1'b1) begin n_fail++; $display("FAIL flush_p1gnt: got %b want 1", gnt1_o); end
    tick();
    req1_i = 1'b0; flush0_i = 1'b0;
    n_cmp++; if (rvalid1_o !== 1'b1 || rdata_o !== exp_word(29'd5)) begin n_fail++; $display("FAIL flush_p1: got %b/%h want 1/%h", rvalid1_o, rdata_o, exp_word(29'd5)); end
    tick();
  endtask

  task automatic test_reset_mid();
    req0_i = 1'b1; addr0_i = 32'h30;
    tick();
    addr0_i = 32'h38;
    #1;
    n_cmp++; if (rvalid0_o !== 1'b1 || gnt0_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b%b want 11", rvalid0_o, gnt0_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({gnt0_o, gnt1_o, rom_ce_o} !== 3'b000) begin n_fail++; $display("FAIL midrst_comb: got %b want 000", {gnt0_o, gnt1_o, rom_ce_o}); end
    n_cmp++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h want 0", rom_addr_o); end
    n_cmp++; if ({rvalid0_o, rvalid1_o, rerr_o} !== 3'b000 || rdata_o !== 64'h0) begin n_fail++; $display("FAIL midrst_regs: got %b/%h want 000/0", {rvalid0_o, rvalid1_o, rerr_o}, rdata_o); end
    tick(); tick();
    req0_i = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++; if ({rvalid0_o, rvalid1_o} !== 2'b00) begin n_fail++; $display("FAIL midrst_norsp: got %b want 00", {rvalid0_o, rvalid1_o}); end
    req0_i = 1'b1; addr0_i = 32'h40; req1_i = 1'b1; addr1_i = 32'h48;
    #1;
    n_cmp++; if ({gnt0_o, gnt1_o} !== 2'b10) begin n_fail++; $display("FAIL midrst_tie: got %b want 10", {gnt0_o, gnt1_o}); end
    tick();
    req0_i = 1'b0; req1_i = 1'b0;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if ({rom_ce_o, gnt0_o, gnt1_o, rvalid0_o, rvalid1_o} !== 5'b00000) begin n_fail++; $display("FAIL idle_ctl[%0d]: got %b want 00000", k, {rom_ce_o, gnt0_o, gnt1_o, rvalid0_o, rvalid1_o}); end
      n_cmp++; if (rdata_o !== exp_word(29'd8)) begin n_fail++; $display("FAIL idle_hold[%0d]: got %h want %h", k, rdata_o, exp_word(29'd8)); end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_port0();
    test_addr_errors();
    test_flush();
    test_reset_mid();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
